// File: rtl/tvip_reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_t      : sequencer FSM states
//   lowest_set_index : index of the lowest set bit of a 32-bit vector, used to
//                      pick the next pending channel during a staggered release
package tvip_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    POR_SYNC = 2'd0,
    ASSERT   = 2'd1,
    RELEASE  = 2'd2,
    IDLE     = 2'd3
  } seq_state_t;

  // Priority search from the top down so the lowest set bit wins.
  // Result is 0 for an all-zero input; callers only use it with pending bits set.
  function automatic logic [4:0] lowest_set_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tvip_reset_sequencer_if.sv
// Control/status bundle of the reset sequencer.
//   request         : single-cycle software reset request
//   channel_mask    : channels taking part in a software reset
//   duration        : assertion length in cycles (0 behaves as 1)
//   stagger         : cycles between consecutive channel releases
//   channel_reset_n : per-channel active-low resets
//   busy            : sequence in progress
//   done            : one-cycle pulse on sequence completion
//
// Handshake: request is a one-cycle pulse sampled on the rising clock edge.
// It is accepted only in a cycle where busy is low; a request seen while busy
// is dropped, never queued. channel_mask, duration and stagger are sampled
// only on the accepting edge.
interface tvip_reset_sequencer_if #(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_WIDTH = 16
) ();

  logic                     request;
  logic [CHANNELS-1:0]      channel_mask;
  logic [COUNTER_WIDTH-1:0] duration;
  logic [COUNTER_WIDTH-1:0] stagger;
  logic [CHANNELS-1:0]      channel_reset_n;
  logic                     busy;
  logic                     done;

  modport master (
    output request, channel_mask, duration, stagger,
    input  channel_reset_n, busy, done
  );

  modport slave (
    input  request, channel_mask, duration, stagger,
    output channel_reset_n, busy, done
  );

endinterface

// File: rtl/tvip_reset_synchronizer.sv
// Reset synchronizer: asynchronous assertion, synchronous deassertion.
//   clk          : clock
//   reset_n      : asynchronous active-low reset input
//   sync_reset_n : reset_n released through STAGES flops
module tvip_reset_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_reset_n
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign sync_reset_n = chain[STAGES-1];

endmodule

// File: rtl/tvip_reset_sequencer.sv
// Multi-channel reset sequencer. Asserts the selected channel resets, holds
// them for a programmable number of cycles, then releases them in ascending
// channel order with a programmable stagger.
//   clk       : clock, all state on the rising edge
//   reset_n   : asynchronous active-low reset (forces all channels low)
//   bus       : control/status bundle (slave side)
//   dbg_state : current FSM state
module tvip_reset_sequencer
  import tvip_reset_sequencer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int POR_DURATION  = 16,
  parameter int POR_STAGGER   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tvip_reset_sequencer_if.slave bus,
  output seq_state_t            dbg_state
);

  localparam logic [COUNTER_WIDTH-1:0] POR_LOAD = COUNTER_WIDTH'(POR_DURATION - 1);
  localparam logic [COUNTER_WIDTH-1:0] POR_STAG = COUNTER_WIDTH'(POR_STAGGER);

  seq_state_t               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] stag_q, stag_d;
  logic [CHANNELS-1:0]      pend_q, pend_d;
  logic [CHANNELS-1:0]      rst_q, rst_d;
  logic                     done_q, done_d;
  logic                     sync_n;

  logic [31:0]              pend_ext;
  logic [4:0]               low_idx;
  logic [CHANNELS-1:0]      rel_sel;
  logic [CHANNELS-1:0]      pend_left;

  tvip_reset_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_reset_n (sync_n)
  );

  // Channels released on a release edge: everything pending when there is no
  // stagger, otherwise only the lowest-index pending one. Masked-out indices
  // are never pending, so they are skipped without costing a cycle.
  assign pend_ext  = 32'(pend_q);
  assign low_idx   = lowest_set_index(pend_ext);
  assign rel_sel   = (stag_q == '0) ? pend_q : (CHANNELS'(1) << low_idx);
  assign pend_left = pend_q & ~rel_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stag_d  = stag_q;
    pend_d  = pend_q;
    rst_d   = rst_q;
    done_d  = 1'b0;

    case (state_q)
      POR_SYNC: begin
        if (sync_n) begin
          state_d = ASSERT;
          cnt_d   = POR_LOAD;
          stag_d  = POR_STAG;
          pend_d  = '1;
          rst_d   = '0;
        end
      end

      // The edge on which the counter reads 0 is itself the first release
      // edge, so the hold lasts exactly max(duration,1) cycles.
      ASSERT, RELEASE: begin
        if (cnt_q == '0) begin
          rst_d  = rst_q | rel_sel;
          pend_d = pend_left;
          cnt_d  = (stag_q == '0) ? '0 : stag_q - 1'b1;
          if (pend_left == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      IDLE: begin
        if (bus.request) begin
          if (bus.channel_mask != '0) begin
            state_d = ASSERT;
            pend_d  = bus.channel_mask;
            rst_d   = rst_q & ~bus.channel_mask;
            cnt_d   = (bus.duration == '0) ? '0 : bus.duration - 1'b1;
            stag_d  = bus.stagger;
          end else begin
            // Nothing to reset: report completion straight away.
            done_d = 1'b1;
          end
        end
      end

      default: state_d = POR_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= POR_SYNC;
      cnt_q   <= '0;
      stag_q  <= '0;
      pend_q  <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stag_q  <= stag_d;
      pend_q  <= pend_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign bus.channel_reset_n = rst_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = done_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_tvip_reset_sequencer.sv
// Self-checking bench for tvip_reset_sequencer. A reference model derives the
// per-cycle expected outputs from release times (hold length + rank*stagger)
// and the bench compares every cycle while disturbing the inputs at random.
module tb_tvip_reset_sequencer;
  import tvip_reset_sequencer_pkg::*;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int SS = 2;
  localparam int PD = 16;
  localparam int PS = 0;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  tvip_reset_sequencer_if #(.CHANNELS(CH), .COUNTER_WIDTH(CW)) bus ();
  seq_state_t dbg_state;

  tvip_reset_sequencer #(
    .CHANNELS(CH), .COUNTER_WIDTH(CW), .SYNC_STAGES(SS),
    .POR_DURATION(PD), .POR_STAGGER(PS)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // {busy, done, channel_reset_n} expected after each successive edge
  logic [CH+1:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: k-th participating channel is released after edge
  // alen + k*s (edge 0 = the accepting edge / first edge after reset_n rises).
  task automatic model_seq(input logic [CH-1:0] mask, input int alen, input int s,
                           output int last);
    int rel [CH];
    int k;
    logic [CH-1:0] r;
    k = 0;
    last = 0;
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        rel[c] = alen + k * s;
        k++;
        if (rel[c] > last) last = rel[c];
      end else begin
        rel[c] = -1;
      end
    end
    for (int n = 0; n < last + 3; n++) begin
      for (int c = 0; c < CH; c++) r[c] = !mask[c] || (n >= rel[c]);
      exp_q.push_back({(n < last), (n == last), r});
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_random_inputs(input logic allow_req);
    bus.channel_mask = CH'($urandom_range(0, 15));
    bus.duration     = CW'($urandom_range(0, 9));
    bus.stagger      = CW'($urandom_range(0, 6));
    bus.request      = allow_req && ($urandom_range(0, 3) == 0);
  endtask

  // Consume exp_q one edge at a time. Requests are only injected for edges
  // where the sequencer is still busy, so they must be ignored.
  task automatic check_seq(input string name, input int last);
    logic [CH+1:0] e;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bus.channel_reset_n !== e[CH-1:0]) begin
        errors++;
        $display("FAIL %s cycle %0d channel_reset_n got %b exp %b", name, n, bus.channel_reset_n, e[CH-1:0]);
      end
      checks++;
      if (bus.busy !== e[CH+1]) begin
        errors++;
        $display("FAIL %s cycle %0d busy got %b exp %b", name, n, bus.busy, e[CH+1]);
      end
      checks++;
      if (bus.done !== e[CH]) begin
        errors++;
        $display("FAIL %s cycle %0d done got %b exp %b", name, n, bus.done, e[CH]);
      end
      drive_random_inputs(n + 1 <= last);
      n++;
    end
    bus.request = 1'b0;
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL %s end state got %0d exp %0d", name, dbg_state, IDLE);
    end
  endtask

  task automatic check_in_reset(input string name);
    checks++;
    if (bus.channel_reset_n !== '0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s rst/busy/done got %b/%b/%b exp 0000/1/0", name, bus.channel_reset_n, bus.busy, bus.done);
    end
    checks++;
    if (dbg_state !== POR_SYNC) begin
      errors++;
      $display("FAIL %s state got %0d exp %0d", name, dbg_state, POR_SYNC);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_power_on();
    int last;
    @(negedge clk);
    reset_n = 1'b1;
    model_seq('1, SS + PD, PS, last);
    check_seq("power_on", last);
  endtask

  task automatic test_reset();
    bus.request      = 1'b0;
    bus.channel_mask = '0;
    bus.duration     = '0;
    bus.stagger      = '0;
    #1 reset_n = 1'b0;
    #2 check_in_reset("reset_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      drive_random_inputs(1'b1);
      check_in_reset("reset_hold");
    end
    bus.request = 1'b0;
    test_power_on();
  endtask

  task automatic test_sw(input string name, input logic [CH-1:0] mask,
                         input int d, input int s);
    int last;
    bus.channel_mask = mask;
    bus.duration     = CW'(d);
    bus.stagger      = CW'(s);
    bus.request      = 1'b1;
    model_seq(mask, (d == 0) ? 1 : d, s, last);
    check_seq(name, last);
  endtask

  task automatic test_mask_zero();
    bus.channel_mask = '0;
    bus.duration     = CW'(4);
    bus.stagger      = CW'(2);
    bus.request      = 1'b1;
    @(posedge clk);
    #1;
    bus.request = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.channel_reset_n !== '1) begin
      errors++;
      $display("FAIL mask_zero pulse done/busy/rst got %b/%b/%b exp 1/0/1111", bus.done, bus.busy, bus.channel_reset_n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.channel_reset_n !== '1) begin
      errors++;
      $display("FAIL mask_zero after done/busy/rst got %b/%b/%b exp 0/0/1111", bus.done, bus.busy, bus.channel_reset_n);
    end
  endtask

  task automatic test_reset_mid_release();
    bus.channel_mask = '1;
    bus.duration     = CW'(3);
    bus.stagger      = CW'(4);
    bus.request      = 1'b1;
    @(posedge clk);
    #1;
    bus.request = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Channel 0 released after edge 3, others still held.
    checks++;
    if (bus.channel_reset_n !== 4'b0001 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_release pre rst/busy got %b/%b exp 0001/1", bus.channel_reset_n, bus.busy);
    end
    reset_n = 1'b0;
    #1 check_in_reset("mid_release_async");
    repeat (2) @(posedge clk);
    #1 check_in_reset("mid_release_hold");
    test_power_on();
  endtask

  initial begin
    test_reset();
    test_sw("sw_1011_d5_s3", 4'b1011, 5, 3);
    test_sw("sw_1111_d0_s0", 4'b1111, 0, 0);
    test_sw("sw_1000_d1_s7", 4'b1000, 1, 7);
    test_sw("sw_0101_d2_s1", 4'b0101, 2, 1);
    test_mask_zero();
    for (int i = 0; i < 12; i++) begin
      test_sw("sw_random", CH'($urandom_range(1, 15)), $urandom_range(0, 8), $urandom_range(0, 5));
    end
    test_mask_zero();
    test_reset_mid_release();
    test_sw("sw_after_reset", 4'b0110, 3, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tvip_reset_sequencer.md
# tvip_reset_sequencer

Synthesizable, parametrised reset generator that drives CHANNELS independent active-low reset outputs from one clock. On power-on and on software request it asserts the selected channels, holds them for a programmable cycle count, then releases them synchronously in ascending channel order with a programmable stagger. It sits at the top of each TVIP test harness or DUT wrapper, feeding per-domain resets to agents and design blocks.

## Interface
- CHANNELS, 4: number of reset outputs (1..32)
- COUNTER_WIDTH, 16: width of duration and stagger counters
- SYNC_STAGES, 2: deassertion synchronizer depth (>=2)
- POR_DURATION, 16: assertion length in cycles after power-on reset (>=1)
- POR_STAGGER, 0: release spacing after power-on reset

- clk  input  1  clock; all state rising-edge
- reset_n  input  1  asynchronous active-low reset
- request  input  1  single-cycle software reset request
- channel_mask  input  CHANNELS  channels participating in a software reset
- duration  input  COUNTER_WIDTH  assertion length in cycles; 0 treated as 1
- stagger  input  COUNTER_WIDTH  cycles between consecutive channel releases
- channel_reset_n  output  CHANNELS  per-channel active-low reset
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when a sequence completes

## Operation
- States: POR_SYNC, ASSERT, RELEASE, IDLE.
- reset_n low (asynchronous): channel_reset_n all 0, busy 1, done 0, state POR_SYNC, synchronizer cleared, counters 0.
- POR_SYNC: waits for synchronized reset_n; then ASSERT with latched duration = POR_DURATION, stagger = POR_STAGGER, mask = all ones.
- IDLE + request with channel_mask != 0: latch mask, duration, stagger; masked channels' channel_reset_n go 0; busy 1; ASSERT. Unmasked channels stay 1 throughout.
- IDLE + request with channel_mask == 0: no reset asserted, busy stays 0, done pulses next cycle.
- request while busy: ignored, no queuing.
- ASSERT: counter loaded with max(duration,1)-1, decrements per cycle; on the cycle it reads 0, move to RELEASE.
- RELEASE, stagger == 0: all pending channels released on the same edge.
- RELEASE, stagger S >= 1: lowest-index pending channel released, counter loaded S-1; next pending channel released when counter reaches 0. Masked-out indices skipped in zero cycles (priority search over pending bits).
- Edge that releases the last pending channel: state IDLE, busy 0, done 1 for exactly one cycle.
- Inputs duration, stagger, channel_mask only sampled at request acceptance; later changes have no effect on the running sequence.

## Timing
- Reset values: channel_reset_n = 0, busy = 1, done = 0.
- Power-on: reset_n rising at edge 0 -> synchronized high after SYNC_STAGES edges; ASSERT then lasts POR_DURATION cycles; first release edge follows.
- Software: request high at cycle t -> assertion visible at t+1; first release at t+1+max(duration,1); release k (k-th participating, from 0) at that edge + k*S.
- done asserted in the cycle after the final release edge is sampled, i.e. coincident with busy falling.
- reset_n asserted mid-sequence: immediate asynchronous assertion of all channels, state POR_SYNC, in-flight sequence discarded.
- All deassertions are synchronous to clk; only assertion by reset_n is asynchronous.
- Counter arithmetic is unsigned COUNTER_WIDTH; no wrap occurs since load values never exceed 2^COUNTER_WIDTH-1.

## Structure
- Package tvip_reset_sequencer_pkg: state enum (POR_SYNC, ASSERT, RELEASE, IDLE), and a lowest-set-bit function used for channel selection.
- Sub-module tvip_reset_synchronizer: SYNC_STAGES flop chain, asynchronous clear, synchronous release of reset_n.
- Top holds FSM, shared down-counter, pending-channel register and output register.

## Test plan
- Power-on, defaults (CHANNELS=4, POR_DURATION=16, POR_STAGGER=0) -> all outputs 0, then all 1 on the same edge 2+16 cycles after reset_n rises; done pulses once.
- request, mask 4'b1011, duration 5, stagger 3 -> channels 0,1,3 low from t+1; release at t+6, t+9, t+12; channel 2 stays 1; done at t+12 edge.
- duration 0, stagger 0, mask 4'b1111 -> all low for exactly one cycle, released together at t+2.
- request while busy, and request with mask 0 while idle -> first ignored (no output change); second yields done one cycle later, busy stays 0.
- reset_n dropped during RELEASE after channel 0 released -> all channel_reset_n 0 asynchronously, busy 1, full power-on sequence resumes after reset_n rises.
